// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO control slice: default geometry,
// pointer-width helper and the arbitration grant encoding.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_PTR_WIDTH  = DEF_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } grant_t;

  // One extra pointer bit distinguishes full from empty when the low bits match.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer register with increment enable and synchronous
// active-high reset; used for both the write and the read side.
module fifo_ptr #(
  parameter int PW = fifo_pkg::DEF_PTR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PW'(1);
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control: owns the pointers, arbitrates write/read round-robin for the
// single-access memory, and derives occupancy, threshold and sticky error flags.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 1 << ADDR_WIDTH,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_req,
  input  logic                  rd_req,
  input  logic                  clr_err,
  output logic                  fifo_we,
  output logic                  fifo_rd,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] AF_C = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C = PW'(AE_LEVEL);
  // A depth that disagrees with the pointer geometry would corrupt the flags,
  // so such a build never grants anything instead.
  localparam bit PARAMS_OK = (DATA_WIDTH > 0) && (FIFO_DEPTH == (1 << ADDR_WIDTH));

  logic   wr_ok;
  logic   rd_ok;
  logic   contended;
  logic   last_wr;
  grant_t grant;

  fifo_ptr #(.PW(PW)) u_wptr (
    .clk (clk),
    .rst (rstn),
    .inc (fifo_we),
    .ptr (wptr)
  );

  fifo_ptr #(.PW(PW)) u_rptr (
    .clk (clk),
    .rst (rstn),
    .inc (fifo_rd),
    .ptr (rptr)
  );

  assign empty        = (wptr == rptr);
  assign full         = (wptr[PW-1] != rptr[PW-1]) && (wptr[PW-2:0] == rptr[PW-2:0]);
  assign count        = wptr - rptr;
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign wr_ok     = PARAMS_OK && wr_req && !full;
  assign rd_ok     = PARAMS_OK && rd_req && !empty;
  assign contended = wr_ok && rd_ok;

  always_comb begin
    grant = GNT_NONE;
    if (contended) begin
      grant = last_wr ? GNT_RD : GNT_WR;
    end else if (wr_ok) begin
      grant = GNT_WR;
    end else if (rd_ok) begin
      grant = GNT_RD;
    end
    if (rstn) begin
      grant = GNT_NONE;
    end
  end

  assign fifo_we = (grant == GNT_WR);
  assign fifo_rd = (grant == GNT_RD);

  // Error set takes precedence over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rstn) begin
      last_wr   <= 1'b0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (contended) begin
        last_wr <= fifo_we;
      end
      rd_valid  <= fifo_rd;
      overflow  <= (wr_req && full)  || (overflow  && !clr_err);
      underflow <= (rd_req && empty) || (underflow && !clr_err);
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with a behavioural memory beside it and a
// read-data scoreboard fed from an independent reference of the FIFO contents.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       wr_req, rd_req, clr_err;
  logic       fifo_we, fifo_rd, rd_valid;
  logic [3:0] wptr, rptr, count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  logic [7:0] wdata;
  logic [7:0] o_data;
  logic [7:0] mem [8];

  int checks = 0;
  int errors = 0;

  logic [3:0] m_wptr, m_rptr;
  logic       m_last_wr, m_ovf, m_unf;
  logic [7:0] m_data [$];
  logic [7:0] exp_rd [$];

  always #5 clk = ~clk;

  fifo_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .clr_err      (clr_err),
    .fifo_we      (fifo_we),
    .fifo_rd      (fifo_rd),
    .wptr         (wptr),
    .rptr         (rptr),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always @(posedge clk) begin
    if (fifo_we) mem[wptr[2:0]] <= wdata;
    if (fifo_rd) o_data <= mem[rptr[2:0]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_wptr = '0; m_rptr = '0; m_last_wr = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    m_data.delete();
    exp_rd.delete();
  endtask

  // One cycle of traffic: drives at the falling edge, checks grants against the
  // reference just before the rising edge and read data / errors just after it.
  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d,
                      output logic gw_seen, output logic gr_seen);
    logic [3:0] mc;
    logic fm, em, wok, rok, gw, gr;
    logic [7:0] e;
    wr_req = w; rd_req = r; clr_err = c; wdata = d;
    #1;
    mc  = m_wptr - m_rptr;
    fm  = (mc == 4'd8);
    em  = (mc == 4'd0);
    wok = w & ~fm;
    rok = r & ~em;
    gw  = wok & (~rok | ~m_last_wr);
    gr  = rok & ~gw;
    gw_seen = fifo_we;
    gr_seen = fifo_rd;
    checks++;
    if (fifo_we !== gw || fifo_rd !== gr) begin
      errors++;
      $display("FAIL grant: we=%b rd=%b, required we=%b rd=%b", fifo_we, fifo_rd, gw, gr);
    end
    @(posedge clk);
    if (gw) begin m_data.push_back(d); m_wptr = m_wptr + 4'd1; end
    if (gr) begin exp_rd.push_back(m_data.pop_front()); m_rptr = m_rptr + 4'd1; end
    if (wok && rok) m_last_wr = gw;
    if (w && fm) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (r && em) m_unf = 1'b1; else if (c) m_unf = 1'b0;
    #1;
    checks++;
    if (rd_valid !== gr) begin
      errors++;
      $display("FAIL rd_valid: got %b, required %b", rd_valid, gr);
    end
    if (rd_valid === 1'b1 && exp_rd.size() > 0) begin
      e = exp_rd.pop_front();
      checks++;
      if (o_data !== e) begin
        errors++;
        $display("FAIL read data: got %02h, required %02h", o_data, e);
      end
    end
    checks++;
    if (overflow !== m_ovf || underflow !== m_unf) begin
      errors++;
      $display("FAIL error flags: ovf=%b unf=%b, required ovf=%b unf=%b", overflow, underflow, m_ovf, m_unf);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b1; wr_req = 1'b1; rd_req = 1'b1; clr_err = 1'b0; wdata = 8'h00;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (fifo_we !== 1'b0 || fifo_rd !== 1'b0) begin
        errors++;
        $display("FAIL reset strobes: we=%b rd=%b, required 0 0", fifo_we, fifo_rd);
      end
    end
    rstn = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    model_reset();
    #1;
    checks++;
    if (wptr !== 4'd0 || rptr !== 4'd0 || count !== 4'd0) begin
      errors++;
      $display("FAIL reset ptrs: wptr=%0d rptr=%0d count=%0d, required 0 0 0", wptr, rptr, count);
    end
    checks++;
    if ({empty, almost_empty, full, almost_full, overflow, underflow, rd_valid} !== 7'b1100000) begin
      errors++;
      $display("FAIL reset flags: e=%b ae=%b f=%b af=%b ovf=%b unf=%b rv=%b, required 1 1 0 0 0 0 0",
               empty, almost_empty, full, almost_full, overflow, underflow, rd_valid);
    end
    checks++;
    if (fifo_we !== 1'b0 || fifo_rd !== 1'b0) begin
      errors++;
      $display("FAIL idle strobes: we=%b rd=%b, required 0 0", fifo_we, fifo_rd);
    end
  endtask

  task automatic test_fill();
    logic gw, gr;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'h10 + 8'(i), gw, gr);
      checks++;
      if (count !== 4'(i + 1) || almost_full !== (i + 1 >= 7) || full !== (i == 7)) begin
        errors++;
        $display("FAIL fill %0d: count=%0d af=%b full=%b, required %0d %b %b",
                 i, count, almost_full, full, i + 1, (i + 1 >= 7), (i == 7));
      end
    end
    step(1'b1, 1'b0, 1'b0, 8'hEE, gw, gr);
    checks++;
    if (gw !== 1'b0 || overflow !== 1'b1 || count !== 4'd8) begin
      errors++;
      $display("FAIL overflow: we=%b ovf=%b count=%0d, required 0 1 8", gw, overflow, count);
    end
    step(1'b1, 1'b0, 1'b1, 8'hEE, gw, gr);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL set beats clear: ovf=%b, required 1", overflow);
    end
    step(1'b0, 1'b0, 1'b1, 8'h00, gw, gr);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_err: ovf=%b, required 0", overflow);
    end
  endtask

  task automatic test_drain();
    logic gw, gr;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00, gw, gr);
      checks++;
      if (count !== 4'(7 - i) || empty !== (i == 7) || almost_empty !== (7 - i <= 1)) begin
        errors++;
        $display("FAIL drain %0d: count=%0d empty=%b ae=%b, required %0d %b %b",
                 i, count, empty, almost_empty, 7 - i, (i == 7), (7 - i <= 1));
      end
    end
    step(1'b0, 1'b1, 1'b0, 8'h00, gw, gr);
    checks++;
    if (gr !== 1'b0 || underflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow: rd=%b unf=%b, required 0 1", gr, underflow);
    end
    step(1'b0, 1'b0, 1'b1, 8'h00, gw, gr);
  endtask

  task automatic test_contention();
    logic gw, gr;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h20 + 8'(i), gw, gr);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'h30 + 8'(i), gw, gr);
      checks++;
      if (gw !== (i % 2 == 0) || gr !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL contention %0d: we=%b rd=%b, required %b %b", i, gw, gr, (i % 2 == 0), (i % 2 == 1));
      end
    end
    checks++;
    if (count !== 4'd4) begin
      errors++;
      $display("FAIL contention count: got %0d, required 4", count);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'h00, gw, gr);
  endtask

  task automatic test_full_empty_both();
    logic gw, gr;
    step(1'b1, 1'b1, 1'b0, 8'h41, gw, gr);
    checks++;
    if (gw !== 1'b1 || gr !== 1'b0 || underflow !== 1'b1) begin
      errors++;
      $display("FAIL empty both: we=%b rd=%b unf=%b, required 1 0 1", gw, gr, underflow);
    end
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 8'h42 + 8'(i), gw, gr);
    step(1'b1, 1'b1, 1'b1, 8'h99, gw, gr);
    checks++;
    if (gw !== 1'b0 || gr !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL full both: we=%b rd=%b ovf=%b, required 0 1 1", gw, gr, overflow);
    end
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 8'h00, gw, gr);
    step(1'b0, 1'b0, 1'b1, 8'h00, gw, gr);
  endtask

  task automatic test_wrap();
    logic gw, gr;
    logic wrapped = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_wptr == 4'd15) wrapped = 1'b1;
      step(1'b1, 1'b0, 1'b0, 8'h50 + 8'(i), gw, gr);
      step(1'b0, 1'b1, 1'b0, 8'h00, gw, gr);
      checks++;
      if (wptr !== m_wptr || rptr !== m_rptr || empty !== 1'b1 || full !== 1'b0 || count !== 4'd0) begin
        errors++;
        $display("FAIL wrap %0d: wptr=%0d rptr=%0d e=%b f=%b count=%0d, required %0d %0d 1 0 0",
                 i, wptr, rptr, empty, full, count, m_wptr, m_rptr);
      end
    end
    checks++;
    if (!wrapped) begin
      errors++;
      $display("FAIL wrap coverage: pointer never reached 15, required a 15->0 pass");
    end
  endtask

  task automatic test_reset_mid();
    logic gw, gr;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h70 + 8'(i), gw, gr);
    step(1'b0, 1'b1, 1'b0, 8'h00, gw, gr);
    rstn = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    #1;
    checks++;
    if (fifo_we !== 1'b0 || fifo_rd !== 1'b0) begin
      errors++;
      $display("FAIL mid reset strobes: we=%b rd=%b, required 0 0", fifo_we, fifo_rd);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rd_valid !== 1'b0 || wptr !== 4'd0 || rptr !== 4'd0 || count !== 4'd0 ||
        {empty, almost_empty, full, almost_full, overflow, underflow} !== 6'b110000) begin
      errors++;
      $display("FAIL mid reset state: rv=%b wptr=%0d rptr=%0d count=%0d e=%b ae=%b f=%b af=%b, required 0 0 0 0 1 1 0 0",
               rd_valid, wptr, rptr, count, empty, almost_empty, full, almost_full);
    end
    @(negedge clk);
    rstn = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    model_reset();
    step(1'b1, 1'b1, 1'b0, 8'h88, gw, gr);
    step(1'b0, 1'b1, 1'b0, 8'h00, gw, gr);
  endtask

  initial begin
    rstn = 1'b1; wr_req = 1'b0; rd_req = 1'b0; clr_err = 1'b0; wdata = 8'h00;
    model_reset();
    @(negedge clk);
    test_reset();
    test_fill();
    test_drain();
    test_contention();
    test_full_empty_both();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
